csa_frame_accumulator: RTL and testbench
========================================

# csa_frame_accumulator

Streaming accumulator that sits directly downstream of the 4-operand carry-save adder and consumes its result word, {cout, sum[4:0]}, one sample per handshake. It sums a frame of N such samples internally in redundant carry-save form, so there is no carry chain on the per-sample path. At frame end it resolves the redundant pair into a binary total with an iterative carry-propagate phase, then presents the frame total on a valid/ready output.

## Interface
- IN_W, 6: input sample width ({cout, sum} of the upstream adder; max value 63).
- N, 8: samples per frame; N >= 2.
- ACC_W, 9: accumulator/output width; must satisfy ACC_W >= IN_W + ceil(log2(N)), so no overflow is possible.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  IN_W  sample (unsigned).
- out_valid  output  1  out_data holds a completed frame total.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  ACC_W  unsigned frame total.

## Operation
- Registers:
  - S, C: ACC_W each, carry-save pair.
  - cnt: counts 0..N-1.
  - state: ACCUM, RESOLVE or OUTPUT.
- Reset: state=ACCUM, S=0, C=0, cnt=0, in_ready=1, out_valid=0, out_data=0.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Accept on in_valid & in_ready, with x = zero-extended in_data:
    - S <= S ^ C ^ x.
    - C <= ((S&C)|(S&x)|(C&x)) << 1, truncated to ACC_W.
  - Accepted sample with cnt < N-1: cnt <= cnt+1.
  - Accepted sample with cnt == N-1: cnt <= 0, state <= RESOLVE.
  - No accept: all registers hold.
- RESOLVE:
  - in_ready=0, out_valid=0.
  - If C == 0: state <= OUTPUT; S and C unchanged.
  - Else: S <= S ^ C; C <= (S & C) << 1, truncated.
  - Invariant: S + C (mod 2^ACC_W) equals the frame sum at all times.
- OUTPUT:
  - in_ready=0, out_valid=1, out_data=S.
  - On out_ready: S <= 0, C <= 0, state <= ACCUM.
  - Without out_ready: out_valid and out_data hold stable.
- out_data is driven from S only in OUTPUT; it is 0 in the other states.
- in_valid is ignored whenever in_ready=0. No sample is dropped or double-counted: the upstream holds data under in_ready=0.
- Reset asserted in any state discards the partial frame and any pending output immediately (asynchronously). The next frame starts counting from zero.

## Timing
- in_ready is a pure function of state (no combinational path from in_valid). out_valid is a pure function of state.
- Throughput in ACCUM: one sample per cycle.
- Last sample accepted at edge k puts state in RESOLVE at cycle k+1.
- RESOLVE lasts 1 + r cycles, where r is the number of nonzero-C iterations, 0 <= r <= ACC_W.
- out_valid rises between 1 and ACC_W+1 cycles after the last-sample edge.
- Output handshake at edge m: state is ACCUM and in_ready=1 in cycle m+1, so the first sample of the next frame can be accepted at edge m+1.
- Minimum frame period: N + 2 + r cycles, with out_ready held high.
- Frame total is exact: sum of N samples mod 2^ACC_W, which equals the true sum given the ACC_W rule.

## Test plan
- Zero frame: 8 samples of 0, out_ready=1 -> out_valid pulse with out_data=0; RESOLVE lasts exactly 1 cycle.
- Max frame: 8 samples of 63 back-to-back -> out_data=504; out_valid within 10 cycles of the last accept.
- Ramp with gaps: samples 1..8 with in_valid low on alternate cycles -> out_data=36; cnt advances only on accepted cycles.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid=1 and out_data=36 stable throughout; in_ready=0, and in_valid pulses are not absorbed.
- Reset mid-frame: accept 3 samples of 10, assert rst for 1 cycle, then send 8 samples of 1 -> out_data=8, not 38; all outputs at reset values during rst.
- Back-to-back frames: frame A (8×5) then frame B (8×7) with in_valid constantly high and out_ready=1 -> totals 40 then 56; the first B sample is accepted the cycle after the A output handshake.

Source files
------------

// File: rtl/csa_frame_accumulator.sv
// Frame accumulator for the 4-operand CSA result stream: sums N samples in
// carry-save form, resolves the pair iteratively, then offers the total.
module csa_frame_accumulator #(
    parameter int IN_W  = 6,
    parameter int N     = 8,
    parameter int ACC_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);

    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_RESOLVE,
        ST_OUTPUT
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] s_q, c_q, s_nxt, c_nxt, x;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    always_comb begin
        state_nxt = state;
        s_nxt     = s_q;
        c_nxt     = c_q;
        cnt_nxt   = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        x         = '0;
        x[IN_W-1:0] = in_data;

        case (state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // 3:2 compression of {S, C, x}; no carry chain per sample
                    s_nxt = s_q ^ c_q ^ x;
                    c_nxt = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_RESOLVE;
                    end else begin
                        cnt_nxt = cnt_q + 1'b1;
                    end
                end
            end
            ST_RESOLVE: begin
                // S + C is preserved each step; ends once no carries remain
                if (c_q == '0) begin
                    state_nxt = ST_OUTPUT;
                end else begin
                    s_nxt = s_q ^ c_q;
                    c_nxt = (s_q & c_q) << 1;
                end
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                out_data  = s_q;
                if (out_ready) begin
                    s_nxt     = '0;
                    c_nxt     = '0;
                    state_nxt = ST_ACCUM;
                end
            end
            default: state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACCUM;
            s_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            s_q   <= s_nxt;
            c_q   <= c_nxt;
            cnt_q <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_csa_frame_accumulator.sv
// Bench for csa_frame_accumulator: frame-level reference model plus
// directed frames with hand-computed totals and latencies.
module tb_csa_frame_accumulator;

    localparam int IN_W  = 6;
    localparam int N     = 8;
    localparam int ACC_W = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] out_data;

    csa_frame_accumulator #(.IN_W(IN_W), .N(N), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: running sum of accepted samples, queue of finished totals
    int acc_sum = 0;
    int acc_n   = 0;
    int totals[$];
    int w = 0;              // edges since the completing edge of the pending frame
    bit seen_valid = 0;
    int lat_valid = 0;
    int last_total = -1;
    int last_lat = -1;
    int cyc = 0;
    int hs_cyc = -1;
    int first_acc_cyc = -1;
    bit need_first = 0;

    always @(posedge clk) begin
        int pend0;
        cyc++;
        if (rst) begin
            acc_sum = 0; acc_n = 0; totals.delete(); w = 0; seen_valid = 0;
        end else begin
            pend0 = totals.size();
            if (pend0 > 0 && out_valid && out_ready) begin
                last_total = int'(out_data);
                last_lat   = lat_valid;
                void'(totals.pop_front());
                seen_valid = 0;
                hs_cyc     = cyc;
                need_first = 1;
            end else if (pend0 > 0) begin
                w++;
            end
            if (pend0 == 0 && in_valid) begin
                if (need_first) begin
                    first_acc_cyc = cyc;
                    need_first    = 0;
                end
                acc_sum += int'(in_data);
                acc_n++;
                if (acc_n == N) begin
                    totals.push_back(acc_sum % (1 << ACC_W));
                    acc_sum = 0; acc_n = 0; w = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("rst_in_ready", int'(in_ready), 1);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_data", int'(out_data), 0);
        end else if (totals.size() == 0) begin
            check("in_ready_accum", int'(in_ready), 1);
            check("out_valid_idle", int'(out_valid), 0);
            check("out_data_idle", int'(out_data), 0);
        end else begin
            check("in_ready_busy", int'(in_ready), 0);
            if (out_valid) begin
                check("out_data_total", int'(out_data), totals[0]);
                check("valid_not_at_k1", int'(w >= 1), 1);
                if (!seen_valid) begin
                    seen_valid = 1;
                    lat_valid  = w;
                end
            end else begin
                check("out_valid_dropped", int'(seen_valid), 0);
                check("out_valid_deadline", int'(w < ACC_W + 1), 1);
                check("out_data_resolve", int'(out_data), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        int t = 0;
        in_valid = 1'b1;
        in_data  = IN_W'(v);
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int v, input bit gaps);
        for (int i = 0; i < N; i++) begin
            send(v);
            if (gaps) tick();
        end
    endtask

    task automatic wait_handshake();
        int t = 0;
        while (!(out_valid && out_ready) && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) check("out_timeout", 0, 1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Zero frame: no carries, RESOLVE lasts a single cycle
        send_frame(0, 0);
        wait_handshake();
        check("zero_total", last_total, 0);
        check("zero_latency", last_lat, 1);

        // Max frame: 8*63
        send_frame(63, 0);
        wait_handshake();
        check("max_total", last_total, 504);
        check("max_latency_bound", int'(last_lat <= ACC_W + 1), 1);

        // Ramp 1..8 with idle cycles between samples
        for (int i = 1; i <= N; i++) begin
            send(i);
            tick();
        end
        wait_handshake();
        check("ramp_total", last_total, 36);

        // Backpressure: out_ready low, in_valid pulses must not be absorbed
        out_ready = 1'b0;
        for (int i = 1; i <= N; i++) send(i);
        for (int t = 0; t < 50 && !out_valid; t++) tick();
        for (int t = 0; t < 5; t++) begin
            in_valid = t[0];
            in_data  = 6'd63;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", int'(out_data), 36);
            check("bp_in_ready", int'(in_ready), 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_handshake();
        check("bp_total", last_total, 36);

        // Reset mid-frame discards the partial sum
        for (int i = 0; i < 3; i++) send(10);
        rst = 1'b1;
        #1;
        check("rst_async_ready", int'(in_ready), 1);
        check("rst_async_valid", int'(out_valid), 0);
        tick();
        rst = 1'b0;
        send_frame(1, 0);
        wait_handshake();
        check("post_rst_total", last_total, 8);

        // Back-to-back frames with in_valid held high
        in_valid = 1'b1;
        in_data  = 6'd5;
        for (int n = 0, t = 0; n < 2 * N && t < 200; t++) begin
            if (n == N) in_data = 6'd7;
            if (in_ready) n++;
            tick();
        end
        in_valid = 1'b0;
        check("b2b_gap", first_acc_cyc - hs_cyc, 1);
        check("b2b_total_a", last_total, 40);
        wait_handshake();
        check("b2b_total_b", last_total, 56);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
